sram_responder: RTL and testbench
=================================

# sram_responder

Synthesizable on-chip stand-in for the SLC-3 external SRAM, answering the active-low strobe protocol (Mem_CE/UB/LB/OE/WE) that the control unit drives. It sits on the far side of the memory interface from the ISDU/MAR/MDR datapath. It supplies read data in time for the fetch state's MDR load and commits writes on the second consecutive write-strobe cycle. It also flags malformed strobe sequences and counts committed writes.

## Interface
- ADDR_W, 10: word-address bits actually decoded; the array holds 2^ADDR_W words.
- DATA_W, 16: word width; fixed at 16 for LC-3.
- READ_LAT, 1: cycles from the first sampled OE-low cycle to read data valid; legal range 1..3.
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state except array contents.
- Mem_CE  in  1  chip enable, active-low.
- Mem_UB  in  1  upper-byte enable, active-low.
- Mem_LB  in  1  lower-byte enable, active-low.
- Mem_OE  in  1  output enable (read strobe), active-low.
- Mem_WE  in  1  write enable (write strobe), active-low.
- ADDR  in  20  word address; only ADDR[ADDR_W-1:0] is used, and upper bits alias.
- Data_from_CPU  in  16  write data.
- Data_to_CPU  out  16  read data, registered.
- Data_drive  out  1  bus drive enable for the top-level tristate.
- Rd_valid  out  1  high while Data_to_CPU holds valid data for the current access.
- Err_short  out  1  one-cycle pulse when a write strobe lasts only one cycle.
- Err_conflict  out  1  one-cycle pulse on each cycle with CE, OE and WE all low.
- Wr_count  out  16  number of committed writes.

## Operation
- States: IDLE, RD_WAIT, RD_DRIVE, WR_ARM, WR_HOLD.
- "Selected" means Mem_CE=0. Any cycle with Mem_CE=1 sends the block to IDLE at the next edge.
- IDLE:
  - Selected with WE=0 goes to WR_ARM. WE takes priority over OE, and if OE=0 too, Err_conflict pulses.
  - Otherwise, selected with OE=0 captures ADDR and goes to RD_WAIT, or directly to RD_DRIVE when READ_LAT=1.
- RD_WAIT: counts READ_LAT-1 cycles while OE stays low, then goes to RD_DRIVE. OE high goes to IDLE.
- RD_DRIVE:
  - Data_to_CPU = array[captured addr]. The upper byte is forced to 0x00 if UB=1 and the lower byte if LB=1; lanes are re-evaluated each cycle.
  - Data_drive=1 and Rd_valid=1. Holds while OE=0; OE=1 goes to IDLE.
  - ADDR changes during a read access are ignored.
- WR_ARM:
  - Entered on the first WE-low edge, capturing ADDR and Data_from_CPU.
  - If WE is still low at the next edge: commit to the array under UB/LB byte enables sampled on that commit cycle, increment Wr_count, go to WR_HOLD.
  - If WE rises first: no write, Err_short pulses, go to IDLE.
- WR_HOLD: no further commits while WE stays low. WE=1 goes to IDLE. A write strobe therefore commits exactly once regardless of its length.
- Wr_count wraps 0xFFFF to 0x0000.
- The array is never written except by a commit and is not cleared by Reset.

## Timing
- Reset values: state IDLE, Data_to_CPU=0, Data_drive=0, Rd_valid=0, Err_short=0, Err_conflict=0, Wr_count=0. A pending write is dropped.
- Read, READ_LAT=1:
  - OE is sampled low at edge N.
  - Data_to_CPU, Rd_valid and Data_drive are valid from just after edge N+1.
  - This matches the two-cycle fetch: the CPU loads MDR on edge N+2.
- Read, general: valid from edge N+READ_LAT.
- Read, end of access: Data_drive falls at the first edge that samples OE=1.
- Write:
  - WE sampled low at edges N and N+1 commits at edge N+1.
  - Read-after-write to the same address returns the new data on the next read access.
- Errors: Err_* are registered and appear one cycle after the offending sample.

## Structure
- Add the state enum (sram_resp_state_t) and the READ_LAT legal-range constants to the shared lc3b_types package.
- One sub-module, sram_array: single-port synchronous-write, asynchronous-read RAM of 2^ADDR_W x 16 with two byte-write enables and no reset.
- The FSM, address/data capture registers, error logic and counter live in sram_responder.

## Test plan
- Write 0xBEEF to address 0x003 with WE low 2 cycles and UB=LB=0, then read address 0x003 with OE low 2 cycles → Data_to_CPU=0xBEEF, valid at the second OE cycle; Wr_count=1.
- Write 0xFFFF to 0x005 with UB=1, LB=0 over a previous 0x1234 → a read returns 0x12FF. Read 0x005 with UB=0, LB=1 → 0x1200.
- One-cycle WE pulse at 0x007 holding 0x0000 with data 0xAAAA → Err_short pulses once, 0x007 still reads 0x0000, Wr_count unchanged.
- WE held low 5 cycles → exactly one commit, Wr_count increments by 1. CE, OE and WE all low → Err_conflict each such cycle and a write is performed.
- Reset asserted mid-read in RD_DRIVE → Data_drive/Rd_valid drop immediately. Previously written contents still read back after release. Wr_count=0.
- READ_LAT=3: OE sampled low at edge N → Rd_valid first high after edge N+3. OE released at N+2 → no valid data, back to IDLE.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3 types: SRAM responder state encoding, read latency
// bounds and byte-lane helper.
package lc3b_types;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_WAIT  = 3'd1,
    S_RD_DRIVE = 3'd2,
    S_WR_ARM   = 3'd3,
    S_WR_HOLD  = 3'd4
  } sram_resp_state_t;

  // Active-low byte strobes to a 16-bit keep mask.
  function automatic logic [15:0] lane_mask(
    input logic ub_n,
    input logic lb_n
  );
    return {{8{~ub_n}}, {8{~lb_n}}};
  endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port RAM: synchronous byte-enabled write,
// asynchronous read, no reset.
module sram_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int HALF  = DATA_W / 2;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && be[0]) mem[addr][HALF-1:0] <= wdata[HALF-1:0];
    if (we && be[1]) mem[addr][DATA_W-1:HALF] <= wdata[DATA_W-1:HALF];
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sram_responder.sv
// On-chip SRAM stand-in answering the SLC-3 active-low strobe
// protocol; flags malformed strobes and counts committed writes.
module sram_responder
  import lc3b_types::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_CE,
  input  logic        Mem_UB,
  input  logic        Mem_LB,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [19:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  output logic [15:0] Data_to_CPU,
  output logic        Data_drive,
  output logic        Rd_valid,
  output logic        Err_short,
  output logic        Err_conflict,
  output logic [15:0] Wr_count
);

  // Out-of-range latencies are clamped rather than rejected.
  localparam int LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                       (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX :
                       READ_LAT;
  localparam logic [1:0] CNT_LAST = 2'(LAT - 1);

  sram_resp_state_t  state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [15:0]       dout_q, dout_d;
  logic              drive_q, drive_d;
  logic              valid_q, valid_d;
  logic              short_q, short_d;
  logic              conf_q, conf_d;
  logic [15:0]       wcnt_q, wcnt_d;

  logic              sel;
  logic              mem_we;
  logic [15:0]       rdata;
  logic              unused_addr;

  assign sel         = ~Mem_CE;
  assign unused_addr = ^ADDR[19:ADDR_W];

  sram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (Clk),
    .we    (mem_we),
    .be    ({~Mem_UB, ~Mem_LB}),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    dout_d  = '0;
    drive_d = 1'b0;
    valid_d = 1'b0;
    short_d = 1'b0;
    conf_d  = sel & ~Mem_OE & ~Mem_WE;
    wcnt_d  = wcnt_q;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sel && !Mem_WE) begin
          state_d = S_WR_ARM;
          addr_d  = ADDR[ADDR_W-1:0];
          wdata_d = Data_from_CPU;
        end else if (sel && !Mem_OE) begin
          addr_d  = ADDR[ADDR_W-1:0];
          cnt_d   = 2'd1;
          state_d = (LAT == 1) ? S_RD_DRIVE : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (!sel || Mem_OE) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RD_DRIVE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_RD_DRIVE: begin
        if (!sel || Mem_OE) begin
          state_d = S_IDLE;
        end else begin
          dout_d  = rdata & lane_mask(Mem_UB, Mem_LB);
          drive_d = 1'b1;
          valid_d = 1'b1;
        end
      end
      S_WR_ARM: begin
        if (sel && !Mem_WE) begin
          mem_we  = 1'b1;
          wcnt_d  = wcnt_q + 16'd1;
          state_d = S_WR_HOLD;
        end else begin
          // Strobe too short: drop the write.
          short_d = Mem_WE;
          state_d = S_IDLE;
        end
      end
      S_WR_HOLD: begin
        if (!sel || Mem_WE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      drive_q <= 1'b0;
      valid_q <= 1'b0;
      short_q <= 1'b0;
      conf_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      drive_q <= drive_d;
      valid_q <= valid_d;
      short_q <= short_d;
      conf_q  <= conf_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign Data_to_CPU  = dout_q;
  assign Data_drive   = drive_q;
  assign Rd_valid     = valid_q;
  assign Err_short    = short_q;
  assign Err_conflict = conf_q;
  assign Wr_count     = wcnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// Randomized self-checking bench for sram_responder at read
// latencies 1 and 3, against a word-array reference model.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_n, ub_n, lb_n, oe_n, we_n;
  logic [19:0] addr;
  logic [15:0] wdat;

  logic [15:0] d1, d3, wc1, wc3;
  logic        dr1, dr3, v1, v3, es1, es3, ec1, ec3;

  int errs = 0;
  int checks = 0;

  logic [15:0] ref_mem [1024];
  bit          known [1024];
  logic [15:0] ref_cnt = 16'd0;

  always #5 clk = ~clk;

  sram_responder #(.READ_LAT(1)) dut1 (
    .Clk(clk), .Reset(rst), .Mem_CE(ce_n), .Mem_UB(ub_n),
    .Mem_LB(lb_n), .Mem_OE(oe_n), .Mem_WE(we_n), .ADDR(addr),
    .Data_from_CPU(wdat), .Data_to_CPU(d1), .Data_drive(dr1),
    .Rd_valid(v1), .Err_short(es1), .Err_conflict(ec1),
    .Wr_count(wc1)
  );

  sram_responder #(.READ_LAT(3)) dut3 (
    .Clk(clk), .Reset(rst), .Mem_CE(ce_n), .Mem_UB(ub_n),
    .Mem_LB(lb_n), .Mem_OE(oe_n), .Mem_WE(we_n), .ADDR(addr),
    .Data_from_CPU(wdat), .Data_to_CPU(d3), .Data_drive(dr3),
    .Rd_valid(v3), .Err_short(es3), .Err_conflict(ec3),
    .Wr_count(wc3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
    tick();
  endtask

  function automatic logic [15:0] lanes(input logic [15:0] w,
                                        input logic ub,
                                        input logic lb);
    return {ub ? 8'h00 : w[15:8], lb ? 8'h00 : w[7:0]};
  endfunction

  task automatic do_write(input logic [9:0] a, input logic [15:0] d,
                          input logic ub, input logic lb,
                          input int n, input logic oe);
    ce_n = 1'b0; we_n = 1'b0; oe_n = oe;
    ub_n = ub; lb_n = lb;
    addr = {10'($urandom), a};
    wdat = d;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (!oe) chk("conflict", {ec1, ec3}, 2'b11);
      chk("short_busy", {es1, es3}, 2'b00);
      if (k == 1) begin
        addr = 20'($urandom);
        wdat = 16'($urandom);
      end
    end
    we_n = 1'b1; oe_n = 1'b1;
    tick();
    if (n >= 2) begin
      if (!lb) ref_mem[a][7:0] = d[7:0];
      if (!ub) ref_mem[a][15:8] = d[15:8];
      if (!ub && !lb) known[a] = 1'b1;
      ref_cnt = ref_cnt + 16'd1;
    end
    chk("short", {es1, es3}, (n == 1) ? 2'b11 : 2'b00);
    chk("wr_count1", wc1, ref_cnt);
    chk("wr_count3", wc3, ref_cnt);
    idle();
  endtask

  task automatic do_read(input logic [9:0] a, input logic ub,
                         input logic lb, input int n);
    logic [15:0] exp;
    exp = lanes(ref_mem[a], ub, lb);
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    ub_n = ub; lb_n = lb;
    addr = {10'($urandom), a};
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == 1) addr = 20'($urandom);
      chk("valid1", {v1, dr1}, (k >= 2) ? 2'b11 : 2'b00);
      chk("valid3", {v3, dr3}, (k >= 4) ? 2'b11 : 2'b00);
      if (k >= 2) chk("data1", d1, exp);
      if (k >= 4) chk("data3", d3, exp);
    end
    oe_n = 1'b1;
    tick();
    chk("drive_off", {dr1, v1, dr3, v3}, 4'b0000);
    idle();
  endtask

  initial begin
    logic [9:0]  ra;
    logic [15:0] rd;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 16'h0000;
      known[i] = 1'b0;
    end
    rst = 1'b1;
    ce_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
    oe_n = 1'b1; we_n = 1'b1;
    addr = '0; wdat = '0;
    tick();
    chk("rst_out1", {d1, dr1, v1, es1, ec1, wc1}, 36'h0);
    chk("rst_out3", {d3, dr3, v3, es3, ec3, wc3}, 36'h0);
    rst = 1'b0;
    idle();

    do_write(10'h003, 16'hBEEF, 1'b0, 1'b0, 2, 1'b1);
    do_read(10'h003, 1'b0, 1'b0, 2);
    do_read(10'h003, 1'b0, 1'b0, 5);

    do_write(10'h005, 16'h1234, 1'b0, 1'b0, 2, 1'b1);
    do_write(10'h005, 16'hFFFF, 1'b1, 1'b0, 2, 1'b1);
    chk("merge_model", ref_mem[10'h005], 16'h12FF);
    do_read(10'h005, 1'b0, 1'b0, 4);
    do_read(10'h005, 1'b0, 1'b1, 4);

    do_write(10'h007, 16'h0000, 1'b0, 1'b0, 2, 1'b1);
    do_write(10'h007, 16'hAAAA, 1'b0, 1'b0, 1, 1'b1);
    do_read(10'h007, 1'b0, 1'b0, 4);

    do_write(10'h009, 16'h5A5A, 1'b0, 1'b0, 5, 1'b1);
    do_write(10'h00A, 16'hC3C3, 1'b0, 1'b0, 3, 1'b0);
    do_read(10'h009, 1'b0, 1'b0, 4);
    do_read(10'h00A, 1'b0, 1'b0, 4);

    do_read(10'h003, 1'b1, 1'b0, 2);
    do_read(10'h003, 1'b0, 1'b0, 3);

    for (int i = 0; i < 60; i++) begin
      ra = 10'($urandom_range(0, 15)) + 10'h100;
      rd = 16'($urandom);
      if ($urandom_range(0, 1) == 1 || !known[ra]) begin
        if (known[ra])
          do_write(ra, rd, 1'($urandom), 1'($urandom),
                   $urandom_range(1, 4), 1'b1);
        else
          do_write(ra, rd, 1'b0, 1'b0, $urandom_range(2, 4), 1'b1);
      end else begin
        do_read(ra, 1'($urandom), 1'($urandom),
                $urandom_range(1, 6));
      end
    end

    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    ub_n = 1'b0; lb_n = 1'b0;
    addr = 20'h003;
    tick();
    tick();
    chk("pre_rst_valid", v1, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_read", {dr1, v1, dr3, v3}, 4'b0000);
    chk("rst_count", {wc1, wc3}, 32'h0);
    ref_cnt = 16'd0;
    ce_n = 1'b1; oe_n = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    do_read(10'h003, 1'b0, 1'b0, 4);
    do_read(10'h009, 1'b0, 1'b0, 4);
    do_write(10'h00B, 16'h0F0F, 1'b0, 1'b0, 2, 1'b1);
    do_read(10'h00B, 1'b0, 1'b0, 4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
